// File: rtl/pc_trace_pkg.sv
// Shared types and constants for the PC trace checker: FSM states, mode
// encodings and the checkpoint entry layout at the default widths.
package pc_trace_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int DEPTH_DEF   = 32;
    localparam int DELTA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_SEQ   = 1'b1;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [DELTA_W_DEF-1:0] delta;
    } entry_t;

endpackage

// File: rtl/pc_trace_checker_if.sv
// Configuration, core-PC and result signals of the trace checker; the host
// side uses the master modport, the checker the slave modport.
interface pc_trace_checker_if #(
    parameter int PC_W    = 16,
    parameter int DEPTH   = 32,
    parameter int DELTA_W = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic               cfg_we_i;
    logic [IDX_W-1:0]   cfg_addr_i;
    logic [PC_W-1:0]    cfg_pc_i;
    logic [DELTA_W-1:0] cfg_delta_i;
    logic [IDX_W:0]     num_entries_i;
    logic               mode_i;
    logic               stop_on_fail_i;
    logic               start_i;
    logic [PC_W-1:0]    pc_i;
    logic               busy_o;
    logic               done_o;
    logic               pass_o;
    logic [IDX_W:0]     chk_cnt_o;
    logic [IDX_W:0]     fail_cnt_o;
    logic [IDX_W-1:0]   first_fail_idx_o;
    logic [PC_W-1:0]    first_fail_pc_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_pc_i, cfg_delta_i,
        output num_entries_i, mode_i, stop_on_fail_i, start_i, pc_i,
        input  busy_o, done_o, pass_o, chk_cnt_o, fail_cnt_o,
        input  first_fail_idx_o, first_fail_pc_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_pc_i, cfg_delta_i,
        input  num_entries_i, mode_i, stop_on_fail_i, start_i, pc_i,
        output busy_o, done_o, pass_o, chk_cnt_o, fail_cnt_o,
        output first_fail_idx_o, first_fail_pc_o
    );

endinterface

// File: rtl/pc_trace_table.sv
// Checkpoint table: DEPTH entries of {expected PC, delta}, one synchronous
// write port and an asynchronous read port addressed by the current index.
module pc_trace_table #(
    parameter  int PC_W    = 16,
    parameter  int DEPTH   = 32,
    parameter  int DELTA_W = 8,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   waddr_i,
    input  logic [PC_W-1:0]    wpc_i,
    input  logic [DELTA_W-1:0] wdelta_i,
    input  logic [IDX_W-1:0]   raddr_i,
    output logic [PC_W-1:0]    rpc_o,
    output logic [DELTA_W-1:0] rdelta_o
);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [DELTA_W-1:0] delta_mem [DEPTH];

    // NOTE: the storage array has no reset; contents must survive a reset so
    // a programmed table can be rerun, and it maps onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            pc_mem[waddr_i]    <= wpc_i;
            delta_mem[waddr_i] <= wdelta_i;
        end
    end

    assign rpc_o    = pc_mem[raddr_i];
    assign rdelta_o = delta_mem[raddr_i];

endmodule

// File: rtl/pc_trace_checker.sv
// PC trace checker: compares the core PC against a table of checkpoints,
// either at fixed cycle offsets (exact mode) or in order with timeouts.
module pc_trace_checker
    import pc_trace_pkg::*;
#(
    parameter  int PC_W    = PC_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int DELTA_W = DELTA_W_DEF,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input logic               clk_i,
    input logic               reset,
    pc_trace_checker_if.slave bus
);

    localparam logic [IDX_W:0]   DEPTH_V = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   ONE_V   = (IDX_W+1)'(1);
    localparam logic [DELTA_W-1:0] CNT_ONE = DELTA_W'(1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [DELTA_W-1:0] cnt;
    logic [IDX_W:0]     num_q;
    logic               mode_q;
    logic               stop_q;
    logic               pass_q;
    logic [IDX_W:0]     chk_cnt;
    logic [IDX_W:0]     fail_cnt;
    logic [IDX_W-1:0]   ff_idx;
    logic [PC_W-1:0]    ff_pc;

    logic [PC_W-1:0]    exp_pc;
    logic [DELTA_W-1:0] exp_delta;
    logic [DELTA_W-1:0] d_eff;
    logic               hit, at_limit, eval, fail, last;
    logic [IDX_W:0]     num_clamped, chk_nxt, fail_nxt;

    pc_trace_table #(.PC_W(PC_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) u_table (
        .clk_i    (clk_i),
        .we_i     (bus.cfg_we_i && (state != S_RUN)),
        .waddr_i  (bus.cfg_addr_i),
        .wpc_i    (bus.cfg_pc_i),
        .wdelta_i (bus.cfg_delta_i),
        .raddr_i  (idx),
        .rpc_o    (exp_pc),
        .rdelta_o (exp_delta)
    );

    function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] v);
        return (v == DEPTH_V) ? v : v + ONE_V;
    endfunction

    // NOTE: every signal gets a value before any branch so no latch is inferred.
    always_comb begin
        d_eff       = (exp_delta == '0) ? CNT_ONE : exp_delta;
        hit         = (bus.pc_i == exp_pc);
        at_limit    = (cnt >= d_eff);
        eval        = at_limit;
        fail        = at_limit && !hit;
        if (mode_q == MODE_SEQ) begin
            // A match on the timeout cycle still counts as a pass.
            eval = hit || at_limit;
            fail = !hit && at_limit;
        end
        last        = ({1'b0, idx} == num_q - ONE_V);
        num_clamped = (bus.num_entries_i > DEPTH_V) ? DEPTH_V : bus.num_entries_i;
        chk_nxt     = sat_inc(chk_cnt);
        fail_nxt    = fail ? sat_inc(fail_cnt) : fail_cnt;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            num_q    <= '0;
            mode_q   <= MODE_EXACT;
            stop_q   <= 1'b0;
            pass_q   <= 1'b0;
            chk_cnt  <= '0;
            fail_cnt <= '0;
            ff_idx   <= '0;
            ff_pc    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        num_q    <= num_clamped;
                        mode_q   <= bus.mode_i;
                        stop_q   <= bus.stop_on_fail_i;
                        idx      <= '0;
                        cnt      <= CNT_ONE;
                        chk_cnt  <= '0;
                        fail_cnt <= '0;
                        ff_idx   <= '0;
                        ff_pc    <= '0;
                        if (num_clamped == '0) begin
                            state  <= S_DONE;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            pass_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (eval) begin
                        chk_cnt  <= chk_nxt;
                        fail_cnt <= fail_nxt;
                        idx      <= idx + IDX_W'(1);
                        cnt      <= CNT_ONE;
                        if (fail && (fail_cnt == '0)) begin
                            ff_idx <= idx;
                            ff_pc  <= (mode_q == MODE_SEQ) ? '0 : bus.pc_i;
                        end
                        if (last || (fail && stop_q)) begin
                            state  <= S_DONE;
                            pass_q <= (fail_nxt == '0);
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o           = (state == S_RUN);
    assign bus.done_o           = (state == S_DONE);
    assign bus.pass_o           = pass_q;
    assign bus.chk_cnt_o        = chk_cnt;
    assign bus.fail_cnt_o       = fail_cnt;
    assign bus.first_fail_idx_o = ff_idx;
    assign bus.first_fail_pc_o  = ff_pc;

endmodule

// File: tb/tb_pc_trace_checker.sv
// Directed bench for pc_trace_checker: table-driven runs in both modes plus
// hand sequences for reset, restart-in-RUN, writes during RUN and clamping.
module tb_pc_trace_checker;
    import pc_trace_pkg::*;

    localparam int PC_W    = 16;
    localparam int DEPTH   = 32;
    localparam int DELTA_W = 8;
    localparam int IDX_W   = 5;
    localparam logic [PC_W-1:0] FILL = 16'h0BAD;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_trace_checker_if #(.PC_W(PC_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) bus ();

    pc_trace_checker #(.PC_W(PC_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string                      name;
        logic                       mode;
        logic                       stop;
        logic [IDX_W:0]             num;
        entry_t [2:0]               tbl;
        logic [2:0][7:0]            ev_cyc;
        logic [2:0][PC_W-1:0]       ev_pc;
        int                         e_chk;
        int                         e_fail;
        int                         e_pass;
        int                         e_ffidx;
        int                         e_ffpc;
        int                         e_done;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    logic [PC_W-1:0] sched [256];
    int restart_cyc = 0;
    int we_cyc      = 0;
    vec_t vecs [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic mode, input logic stop,
                                input int num,
                                input int p0, input int d0, input int p1, input int d1,
                                input int p2, input int d2,
                                input int c0, input int v0, input int c1, input int v1,
                                input int c2, input int v2,
                                input int chk, input int fl, input int ps,
                                input int fi, input int fp, input int dn);
        vec_t v;
        v.name = name; v.mode = mode; v.stop = stop; v.num = (IDX_W+1)'(num);
        v.tbl[0] = '{pc: PC_W'(p0), delta: DELTA_W'(d0)};
        v.tbl[1] = '{pc: PC_W'(p1), delta: DELTA_W'(d1)};
        v.tbl[2] = '{pc: PC_W'(p2), delta: DELTA_W'(d2)};
        v.ev_cyc[0] = 8'(c0); v.ev_pc[0] = PC_W'(v0);
        v.ev_cyc[1] = 8'(c1); v.ev_pc[1] = PC_W'(v1);
        v.ev_cyc[2] = 8'(c2); v.ev_pc[2] = PC_W'(v2);
        v.e_chk = chk; v.e_fail = fl; v.e_pass = ps;
        v.e_ffidx = fi; v.e_ffpc = fp; v.e_done = dn;
        return v;
    endfunction

    task automatic prog(input int a, input int p, input int d);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = IDX_W'(a);
        bus.cfg_pc_i    = PC_W'(p);
        bus.cfg_delta_i = DELTA_W'(d);
        tick;
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 3; i++) prog(i, int'(v.tbl[i].pc), int'(v.tbl[i].delta));
        for (int k = 0; k < 256; k++) sched[k] = FILL;
        for (int i = 0; i < 3; i++)
            if (v.ev_cyc[i] != 8'd0) sched[v.ev_cyc[i]] = v.ev_pc[i];
    endtask

    // Start pulse is cycle 0; cycle k ends at the k-th edge after the start
    // edge. Returns the first cycle in which done_o is visible, or -1.
    task automatic run(input logic mode, input logic stop, input int num,
                       input int max_cyc, output int done_cyc);
        bus.mode_i         = mode;
        bus.stop_on_fail_i = stop;
        bus.num_entries_i  = (IDX_W+1)'(num);
        bus.start_i        = 1'b1;
        bus.pc_i           = sched[0];
        tick;
        bus.start_i = 1'b0;
        done_cyc    = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            if (bus.done_o) begin
                done_cyc = k;
                break;
            end
            bus.start_i = (k == restart_cyc);
            if (k == restart_cyc) bus.num_entries_i = '0;
            bus.cfg_we_i = (k == we_cyc);
            if (k == we_cyc) begin
                bus.cfg_addr_i  = IDX_W'(1);
                bus.cfg_pc_i    = PC_W'(777);
                bus.cfg_delta_i = DELTA_W'(3);
            end
            bus.pc_i = sched[k];
            tick;
        end
        bus.start_i  = 1'b0;
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic check_res(input string tag, input int done_cyc, input int e_done,
                             input int e_chk, input int e_fail, input int e_pass,
                             input int e_ffidx, input int e_ffpc);
        check({tag, ".done_cycle"}, done_cyc, e_done);
        check({tag, ".busy"}, int'(bus.busy_o), 0);
        check({tag, ".chk_cnt"}, int'(bus.chk_cnt_o), e_chk);
        check({tag, ".fail_cnt"}, int'(bus.fail_cnt_o), e_fail);
        check({tag, ".pass"}, int'(bus.pass_o), e_pass);
        check({tag, ".ff_idx"}, int'(bus.first_fail_idx_o), e_ffidx);
        check({tag, ".ff_pc"}, int'(bus.first_fail_pc_o), e_ffpc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, int'(bus.busy_o), 0);
        check({tag, ".done"}, int'(bus.done_o), 0);
        check({tag, ".pass"}, int'(bus.pass_o), 0);
        check({tag, ".chk_cnt"}, int'(bus.chk_cnt_o), 0);
        check({tag, ".fail_cnt"}, int'(bus.fail_cnt_o), 0);
        check({tag, ".ff_idx"}, int'(bus.first_fail_idx_o), 0);
        check({tag, ".ff_pc"}, int'(bus.first_fail_pc_o), 0);
    endtask

    initial begin
        int dc;
        bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_pc_i = '0; bus.cfg_delta_i = '0;
        bus.num_entries_i = '0; bus.mode_i = 1'b0; bus.stop_on_fail_i = 1'b0;
        bus.start_i = 1'b0; bus.pc_i = FILL;

        //          name        mode       stop num  table {pc,d} x3        events {cycle,pc} x3     chk fl ps fi fp  done
        vecs[0] = mk("exact_ok",  MODE_EXACT, 0, 3, 35,28, 60,16, 46,8,  28,35, 44,60, 52,46,  3, 0, 1, 0, 0,  53);
        vecs[1] = mk("exact_mis", MODE_EXACT, 0, 3, 35,28, 60,16, 46,8,  28,35, 44,61, 52,46,  3, 1, 0, 1, 61, 53);
        vecs[2] = mk("exact_two", MODE_EXACT, 0, 3, 35,28, 60,16, 46,8,  28,36, 44,61, 52,46,  3, 2, 0, 0, 36, 53);
        vecs[3] = mk("seq_tmo",   MODE_SEQ,   0, 2, 35,10, 60,4,  0,0,   3,35,  0,0,   0,0,    2, 1, 0, 1, 0,  8);
        vecs[4] = mk("stop_fail", MODE_EXACT, 1, 3, 35,28, 60,16, 46,8,  28,99, 44,60, 52,46,  1, 1, 0, 0, 99, 29);
        vecs[5] = mk("exact_d0",  MODE_EXACT, 0, 3, 35,0,  60,0,  46,2,  1,35,  2,60,  4,46,   3, 0, 1, 0, 0,  5);
        vecs[6] = mk("seq_d0",    MODE_SEQ,   0, 2, 35,0,  60,3,  0,0,   3,60,  0,0,   0,0,    2, 1, 0, 0, 0,  4);

        tick; tick;
        reset = 1'b0;
        check_zero("reset");

        for (int i = 0; i < 7; i++) begin
            load_vec(vecs[i]);
            run(vecs[i].mode, vecs[i].stop, int'(vecs[i].num), 200, dc);
            check_res(vecs[i].name, dc, vecs[i].e_done, vecs[i].e_chk, vecs[i].e_fail,
                      vecs[i].e_pass, vecs[i].e_ffidx, vecs[i].e_ffpc);
        end

        // Empty run completes on the cycle after start.
        run(MODE_EXACT, 1'b0, 0, 10, dc);
        check_res("num0", dc, 1, 0, 0, 1, 0, 0);
        check("num0.done", int'(bus.done_o), 1);

        // start_i and cfg_we_i during RUN are both ignored; rerun without reprogramming.
        load_vec(vecs[0]);
        restart_cyc = 10;
        we_cyc      = 20;
        run(MODE_EXACT, 1'b0, 3, 200, dc);
        restart_cyc = 0;
        we_cyc      = 0;
        check_res("run_ign", dc, 53, 3, 0, 1, 0, 0);
        run(MODE_EXACT, 1'b0, 3, 200, dc);
        check_res("run_ign_rerun", dc, 53, 3, 0, 1, 0, 0);

        // Reset in the middle of a run aborts it; the table survives.
        bus.mode_i = MODE_EXACT; bus.stop_on_fail_i = 1'b0; bus.num_entries_i = 6'd3;
        bus.start_i = 1'b1; bus.pc_i = sched[0];
        tick;
        bus.start_i = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            bus.pc_i = sched[k];
            tick;
        end
        check("midrst.chk_before", int'(bus.chk_cnt_o), 1);
        check("midrst.busy_before", int'(bus.busy_o), 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_zero("midrst");
        run(MODE_EXACT, 1'b0, 3, 200, dc);
        check_res("midrst_rerun", dc, 53, 3, 0, 1, 0, 0);

        // num_entries above DEPTH clamps to DEPTH; the count reaches its ceiling.
        for (int i = 0; i < DEPTH; i++) prog(i, 100 + i, 1);
        for (int k = 0; k < 256; k++) sched[k] = FILL;
        for (int k = 1; k <= DEPTH; k++) sched[k] = PC_W'(100 + k - 1);
        run(MODE_EXACT, 1'b0, 63, 100, dc);
        check_res("clamp", dc, DEPTH + 1, DEPTH, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
